// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the data width, the ALU opcodes and the response-slot FSM encoding.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU: ADD/SUB/AND/OR, results wrap modulo 2^DATA_W.
// No carry or borrow is produced; zero_o flags an all-zero result.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           alu_op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  always_comb begin
    result_o = '0;
    unique case (alu_op_i)
      OP_ADD: result_o = a_i + b_i;
      OP_SUB: result_o = a_i - b_i;
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      default: result_o = '0;
    endcase
    zero_o = (result_o == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; a single response register holds the result.
// Handshakes: a transfer happens on a cycle where valid and ready are both 1.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req0_op,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req1_op,
  output logic              req1_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_id,
  output arb_state_e        dbg_state_o,
  output logic              dbg_ptr_o
);

  arb_state_e        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              id_q, id_d;

  logic              slot_free;
  logic              gnt_vld;
  logic              gnt_id;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic              alu_zero;
  alu_op_e           alu_op;

  // Grant: pointer decides only under contention; fixed priority pins it to 0.
  always_comb begin
    slot_free  = (state_q == ST_EMPTY) || rsp_ready;
    gnt_vld    = !reset && slot_free && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) gnt_id = RR_EN ? ptr_q : 1'b0;
    else                          gnt_id = req1_valid;
    req0_ready = gnt_vld && !gnt_id;
    req1_ready = gnt_vld && gnt_id;
  end

  always_comb begin
    alu_a  = gnt_id ? req1_a : req0_a;
    alu_b  = gnt_id ? req1_b : req0_b;
    alu_op = alu_op_e'(gnt_id ? req1_op : req0_op);
  end

  alu u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .alu_op_i (alu_op),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (gnt_vld) state_d = ST_FULL;
      ST_FULL:  if (!gnt_vld && rsp_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid   = (state_q == ST_FULL);
    dbg_state_o = state_q;
    dbg_ptr_o   = ptr_q;
  end

  // Response data and pointer move only on an accepted transfer.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    if (gnt_vld) begin
      result_d = alu_result;
      zero_d   = alu_zero;
      id_d     = gnt_id;
      ptr_d    = !gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      id_q     <= 1'b0;
      ptr_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
    end
  end

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_id     = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus;
// a cycle model of the arbitration rules checks both every cycle, plus literal checks.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;

  logic       rr_r0, rr_r1, rr_v, rr_z, rr_id, rr_ptr;
  logic [7:0] rr_res;
  arb_state_e rr_st;
  logic       fp_r0, fp_r1, fp_v, fp_z, fp_id, fp_ptr;
  logic [7:0] fp_res;
  arb_state_e fp_st;

  int n_cmp = 0;
  int n_err = 0;

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  logic       m_rv [2];
  logic [7:0] m_res [2];
  logic       m_zero [2];
  logic       m_id [2];
  logic       m_ptr [2];

  always #5 clk = ~clk;

  alu_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(rr_r0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(rr_r1),
    .rsp_valid(rr_v), .rsp_ready(rsp_ready), .rsp_result(rr_res), .rsp_zero(rr_z), .rsp_id(rr_id),
    .dbg_state_o(rr_st), .dbg_ptr_o(rr_ptr)
  );

  alu_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(fp_r0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(fp_r1),
    .rsp_valid(fp_v), .rsp_ready(rsp_ready), .rsp_result(fp_res), .rsp_zero(fp_z), .rsp_id(fp_id),
    .dbg_state_o(fp_st), .dbg_ptr_o(fp_ptr)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] calc(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return a & b;
      default: return a | b;
    endcase
  endfunction

  // Returns {grant_valid, grant_id} for model k from the current inputs.
  function automatic logic [1:0] model_grant(input int k);
    logic free;
    free = !m_rv[k] || rsp_ready;
    if (reset || !free || !(req0_valid || req1_valid)) return 2'b00;
    if (req0_valid && req1_valid) return {1'b1, (k == 0) ? m_ptr[0] : 1'b0};
    return {1'b1, req1_valid};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [1:0] g;
      g = model_grant(k);
      if (reset) begin
        m_rv[k] = 1'b0; m_res[k] = 8'h00; m_zero[k] = 1'b0; m_id[k] = 1'b0; m_ptr[k] = 1'b0;
      end else if (g[1]) begin
        m_res[k]  = g[0] ? calc(req1_op, req1_a, req1_b) : calc(req0_op, req0_a, req0_b);
        m_zero[k] = (m_res[k] == 8'h00);
        m_id[k]   = g[0];
        m_rv[k]   = 1'b1;
        m_ptr[k]  = !g[0];
      end else if (rsp_ready) begin
        m_rv[k] = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [1:0] g0, g1;
    g0 = model_grant(0);
    g1 = model_grant(1);
    check("rr_ready0", 8'(rr_r0), 8'(g0[1] && !g0[0]));
    check("rr_ready1", 8'(rr_r1), 8'(g0[1] && g0[0]));
    check("fp_ready0", 8'(fp_r0), 8'(g1[1] && !g1[0]));
    check("fp_ready1", 8'(fp_r1), 8'(g1[1] && g1[0]));
    check("rr_valid", 8'(rr_v), 8'(m_rv[0]));
    check("fp_valid", 8'(fp_v), 8'(m_rv[1]));
    check("rr_state", 8'(rr_st == ST_FULL), 8'(m_rv[0]));
    check("fp_state", 8'(fp_st == ST_FULL), 8'(m_rv[1]));
    if (m_rv[0]) begin
      check("rr_result", rr_res, m_res[0]);
      check("rr_zero", 8'(rr_z), 8'(m_zero[0]));
      check("rr_id", 8'(rr_id), 8'(m_id[0]));
    end
    if (m_rv[1]) begin
      check("fp_result", fp_res, m_res[1]);
      check("fp_zero", 8'(fp_z), 8'(m_zero[1]));
      check("fp_id", 8'(fp_id), 8'(m_id[1]));
    end
  end

  task automatic set_req(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] op0,
                         input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] op1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
  endtask

  // Inputs change just after the falling edge; the next rising edge samples them.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic       exp_id [4];
    logic [7:0] exp_res [4];
    exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_res = '{8'h00, 8'hFF, 8'h00, 8'hFF};

    reset = 1'b1; rsp_ready = 1'b0;
    set_req(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 2'd0);
    step();
    set_req(1'b1, 8'h01, 8'h01, 2'd0, 1'b1, 8'h02, 8'h02, 2'd0);
    #1;
    check("reset_ready0", 8'(rr_r0), 8'h00);
    check("reset_ready1", 8'(rr_r1), 8'h00);
    step();
    check("reset_valid", 8'(rr_v), 8'h00);
    check("reset_result", rr_res, 8'h00);
    check("reset_zero", 8'(rr_z), 8'h00);
    check("reset_id", 8'(rr_id), 8'h00);
    check("reset_ptr", 8'(rr_ptr), 8'h00);

    // Contention, round-robin alternates starting with requester 0.
    reset = 1'b0; rsp_ready = 1'b1;
    set_req(1'b1, 8'h07, 8'h07, 2'd1, 1'b1, 8'hF0, 8'h0F, 2'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_cont_id", 8'(rr_id), 8'(exp_id[i]));
      check("rr_cont_res", rr_res, exp_res[i]);
      check("rr_cont_zero", 8'(rr_z), 8'(exp_res[i] == 8'h00));
      check("fp_cont_id", 8'(fp_id), 8'h00);
    end
    set_req(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 2'd0);
    step();
    check("drain_valid", 8'(rr_v), 8'h00);

    // Single request.
    set_req(1'b1, 8'h05, 8'h03, 2'd0, 1'b0, 8'h00, 8'h00, 2'd0);
    step();
    check("single_valid", 8'(rr_v), 8'h01);
    check("single_res", rr_res, 8'h08);
    check("single_zero", 8'(rr_z), 8'h00);
    check("single_id", 8'(rr_id), 8'h00);

    // Backpressure with req1 waiting.
    rsp_ready = 1'b0;
    set_req(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 8'hF0, 8'h3C, 2'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready0", 8'(rr_r0), 8'h00);
      check("bp_ready1", 8'(rr_r1), 8'h00);
      step();
      check("bp_hold_res", rr_res, 8'h08);
      check("bp_hold_id", 8'(rr_id), 8'h00);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready1", 8'(rr_r1), 8'h01);
    step();
    check("bp_next_res", rr_res, 8'h30);
    check("bp_next_id", 8'(rr_id), 8'h01);
    set_req(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 2'd0);
    step();

    // Wrap-around arithmetic.
    set_req(1'b1, 8'hFF, 8'h01, 2'd0, 1'b0, 8'h00, 8'h00, 2'd0);
    step();
    check("wrap_add_res", rr_res, 8'h00);
    check("wrap_add_zero", 8'(rr_z), 8'h01);
    set_req(1'b1, 8'h00, 8'h01, 2'd1, 1'b0, 8'h00, 8'h00, 2'd0);
    step();
    check("wrap_sub_res", rr_res, 8'hFF);
    check("wrap_sub_zero", 8'(rr_z), 8'h00);
    set_req(1'b1, 8'hAA, 8'h55, 2'd2, 1'b0, 8'h00, 8'h00, 2'd0);
    step();
    check("and_res", rr_res, 8'h00);
    check("and_zero", 8'(rr_z), 8'h01);
    set_req(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 2'd0);
    step();

    // Fixed priority: requester 0 keeps winning until it drops.
    set_req(1'b1, 8'h01, 8'h02, 2'd0, 1'b1, 8'h09, 8'h04, 2'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fp_prio_id", 8'(fp_id), 8'h00);
      check("fp_prio_res", fp_res, 8'h03);
    end
    req0_valid = 1'b0;
    step();
    check("fp_after_id", 8'(fp_id), 8'h01);
    check("fp_after_res", fp_res, 8'h05);
    set_req(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 2'd0);
    step();

    // Reset while holding a response under backpressure.
    set_req(1'b1, 8'h10, 8'h20, 2'd0, 1'b0, 8'h00, 8'h00, 2'd0);
    step();
    check("pre_rst_res", rr_res, 8'h30);
    check("pre_rst_ptr", 8'(rr_ptr), 8'h01);
    rsp_ready = 1'b0;
    set_req(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 2'd0);
    step();
    reset = 1'b1;
    step();
    check("rst_mid_valid", 8'(rr_v), 8'h00);
    check("rst_mid_ptr", 8'(rr_ptr), 8'h00);
    check("rst_mid_res", rr_res, 8'h00);
    reset = 1'b0; rsp_ready = 1'b1;
    set_req(1'b1, 8'h01, 8'h01, 2'd0, 1'b1, 8'h0F, 8'hF0, 2'd3);
    step();
    check("post_rst_id", 8'(rr_id), 8'h00);
    check("post_rst_res", rr_res, 8'h02);
    step();
    check("post_rst_id2", 8'(rr_id), 8'h01);
    check("post_rst_res2", rr_res, 8'hFF);
    set_req(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 2'd0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning: 1 = round-robin grant, 0 = fixed priority (requester 0 wins).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  in  1  requester n presents an operation.
REQ-005 req0_a, req0_b / req1_a, req1_b  in  8  operands of requester n.
REQ-006 req0_op / req1_op  in  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-007 req0_ready / req1_ready  out  1  operation of requester n accepted this cycle when valid and ready are both 1.
REQ-008 rsp_valid  out  1  response register holds a result.
REQ-009 rsp_ready  in  1  consumer takes the response when rsp_valid and rsp_ready are both 1.
REQ-010 rsp_result  out  8  ALU result; rsp_zero  out  1  result == 0; rsp_id  out  1  index of the originating requester.

Function
REQ-011 The block SHALL share a single alu instance between two requesters, with one accepted operation per cycle at most.
REQ-012 The output slot SHALL be free when rsp_valid == 0, or when rsp_valid == 1 and rsp_ready == 1 in the same cycle.
REQ-013 Grant rules, when the slot is free:
  - only one requester valid: grant it;
  - both valid with RR_EN = 1: grant the requester named by the priority pointer;
  - both valid with RR_EN = 0: grant requester 0.
REQ-014 reqN_ready SHALL be 1 only for the granted requester and only when the slot is free; it is combinational from the valids, the pointer and the slot state.
REQ-015 The priority pointer SHALL toggle to the non-granted index only on an accepted transfer; otherwise it SHALL hold.
REQ-016 An operation accepted in cycle N SHALL appear on rsp_valid, rsp_result, rsp_zero and rsp_id in cycle N+1 (one-cycle latency).
REQ-017 Result arithmetic SHALL be 8-bit modulo 2^8: ADD wraps (FF+01=00, zero=1); SUB wraps (00-01=FF, zero=0); no carry or borrow output.
REQ-018 FSM states:
  - EMPTY: accept -> FULL, else stay EMPTY;
  - FULL, rsp_ready=0: hold response, both reqN_ready=0;
  - FULL, rsp_ready=1 with a new accept: stay FULL with new data (back-to-back);
  - FULL, rsp_ready=1 with no accept: -> EMPTY.
REQ-019 While rsp_valid=1 and rsp_ready=0, rsp_result, rsp_zero and rsp_id SHALL remain stable.
REQ-020 With both requesters continuously valid, rsp_ready held at 1 and RR_EN=1, grants SHALL strictly alternate, giving 1 result/cycle with no starvation.
REQ-021 A requester dropping valid before acceptance SHALL not alter the pointer or the response register.

Reset
REQ-022 While reset=1 at a clock edge: rsp_valid=0, rsp_result=00, rsp_zero=0, rsp_id=0, pointer=0, state=EMPTY.
REQ-023 During the reset cycle req0_ready and req1_ready SHALL be 0, and reset SHALL discard any held or in-flight response.
REQ-024 The first grant after reset SHALL favour requester 0 under contention.

Structure
REQ-025 Shared package alu_pkg SHALL hold the opcode constants (ADD/SUB/AND/OR, 2-bit), the data width (8) and the FSM state encoding (EMPTY, FULL).
REQ-026 The block SHALL instantiate exactly one sub-module, the team's combinational alu (a, b, alu_op -> result, zero), fed by a grant-selected operand mux; the response register captures its outputs.

Verification
REQ-027 Single request: req0 a=05 b=03 op=00, rsp_ready=1 -> next cycle rsp_valid=1, result=08, zero=0, id=0.
REQ-028 Contention with RR_EN=1: both valid every cycle for 4 cycles (req0 SUB 07,07; req1 OR F0,0F), rsp_ready=1 -> ids 0,1,0,1; results 00 (zero=1), FF, 00, FF.
REQ-029 Backpressure: response FULL with result 08, rsp_ready=0 for 3 cycles, req1 valid -> both readies 0, response stable at 08; first cycle rsp_ready=1 -> req1 accepted, its result appears the following cycle.
REQ-030 Wrap-around: ADD FF+01 -> result 00, zero=1; SUB 00-01 -> result FF, zero=0; AND AA&55 -> 00, zero=1.
REQ-031 Fixed priority: RR_EN=0, both valid for 3 cycles -> ids 0,0,0; req1 is granted only once req0 drops valid.
REQ-032 Reset mid-operation: assert reset while FULL with rsp_ready=0 -> next cycle rsp_valid=0 and pointer=0; a subsequent contention grants requester 0 first.
